// File: rtl/rgb565_frame_streamer.sv
// rgb565_frame_streamer
// Reads a W x H RGB565 frame buffer in raster order through a synchronous
// read port (1-cycle latency) and emits it as a valid/ready pixel stream with
// start-of-frame, end-of-line and end-of-frame markers. A 4-entry FIFO absorbs
// the read latency and sink backpressure. Read issue depends only on
// registered state, so m_ready never reaches mem_rd_en combinationally.

module rgb565_frame_streamer #(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof
);

  localparam int NPIX = W * H;
  localparam int XW   = (W > 1) ? $clog2(W) : 1;
  localparam int YW   = (H > 1) ? $clog2(H) : 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_rd_addr;
  logic          r_inflight;

  logic [15:0]   r_fifo [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [2:0]    w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_last_px;

  // Occupancy counts buffered pixels plus the one read still in flight; at
  // most 2 before issue keeps the FIFO from ever needing more than 4 slots.
  assign w_occupancy = r_count + {2'b00, r_inflight};
  assign w_issue     = (r_state == S_RUN) && (w_occupancy <= 3'd2);
  assign w_push      = r_inflight;
  assign w_valid     = (r_count != 3'd0);
  assign w_pop       = w_valid && m_ready;
  assign w_last_px   = (r_x == X_LAST) && (r_y == Y_LAST);

  // Frame control: accepts start, walks the read address, detects completion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // The done cycle is still IDLE; a start there is ignored.
          if (start && !r_done) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_rd_addr == LAST_ADDR) begin
              r_state <= S_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          // The last pixel is always the only FIFO entry when it pops.
          if (w_pop && w_last_px) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // In-flight flag: read data returns exactly one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Output FIFO: pushes returning read data, pops on each stream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small store is reset so m_data reads 0 out of reset; a
      // real RAM-sized buffer would be left unreset.
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rd_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output raster position: advances on each handshake, wraps per line/frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = w_issue;
  assign mem_addr  = r_rd_addr;
  assign m_valid   = w_valid;
  assign m_data    = r_fifo[r_rd_ptr];
  assign m_sof     = w_valid && (r_x == '0) && (r_y == '0);
  assign m_eol     = w_valid && (r_x == X_LAST);
  assign m_eof     = w_valid && w_last_px;

endmodule

// File: tb/tb_rgb565_frame_streamer.sv
// Bench for rgb565_frame_streamer: a 4x3 instance for directed latency,
// backpressure, random-ready and reset tests, plus a default 320x240 instance
// streaming a full frame concurrently. A per-cycle model tracks pixel index,
// expected read address and done timing from plain raster arithmetic.

module tb_rgb565_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Index 0: 4x3 instance, index 1: 320x240 instance.
  logic [1:0]       rst;
  logic [1:0]       start;
  logic [1:0]       m_ready;
  logic [1:0][15:0] rd_data;
  wire  [1:0]       busy;
  wire  [1:0]       done;
  wire  [1:0]       rd_en;
  wire  [1:0]       m_valid;
  wire  [1:0]       sof;
  wire  [1:0]       eol;
  wire  [1:0]       eof;
  wire  [1:0][15:0] m_data;
  logic [3:0]       s_addr;
  logic [16:0]      b_addr;

  rgb565_frame_streamer #(.W(4), .H(3), .AW(4)) u_small (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_rd_en(rd_en[0]), .mem_addr(s_addr), .mem_rd_data(rd_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .m_sof(sof[0]), .m_eol(eol[0]), .m_eof(eof[0])
  );

  rgb565_frame_streamer u_big (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_rd_en(rd_en[1]), .mem_addr(b_addr), .mem_rd_data(rd_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .m_sof(sof[1]), .m_eol(eol[1]), .m_eof(eof[1])
  );

  // Frame buffers: small mem[i] = A000+i, big mem[i] = i[15:0].
  always @(posedge clk) begin
    if (rd_en[0]) rd_data[0] <= 16'hA000 + {12'h000, s_addr};
    if (rd_en[1]) rd_data[1] <= b_addr[15:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int npix(input int i);
    return (i == 0) ? 12 : 76800;
  endfunction

  function automatic int line_w(input int i);
    return (i == 0) ? 4 : 320;
  endfunction

  function automatic logic [15:0] base(input int i);
    return (i == 0) ? 16'hA000 : 16'h0000;
  endfunction

  // Model state per instance.
  int          k        [2];
  int          rd_next  [2];
  int          hs_total [2];
  int          n_eol    [2];
  int          n_eof    [2];
  bit          exp_done [2];
  bit          prev_stall [2];
  logic [15:0] prev_data  [2];
  logic [16:0] cur_addr;
  logic [15:0] exp_d;

  initial begin
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; rd_next[i] = 0; hs_total[i] = 0; n_eol[i] = 0; n_eof[i] = 0;
      exp_done[i] = 1'b0; prev_stall[i] = 1'b0; prev_data[i] = '0;
    end
  end

  // Compare process: samples mid-cycle, ahead of the edge that acts on it.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cur_addr = (i == 0) ? {13'h0000, s_addr} : b_addr;
      if (rst[i]) begin
        k[i] = 0; rd_next[i] = 0; exp_done[i] = 1'b0; prev_stall[i] = 1'b0;
      end else begin
        check("done_pulse", 32'(done[i]), 32'(exp_done[i]));
        if (exp_done[i]) begin
          check("busy_at_done", 32'(busy[i]), 32'd0);
          k[i] = 0; rd_next[i] = 0; exp_done[i] = 1'b0;
        end
        if (rd_en[i]) begin
          check("rd_addr", 32'(cur_addr), 32'(rd_next[i]));
          check("rd_in_range", 32'(rd_next[i] < npix(i)), 32'd1);
          rd_next[i]++;
          check("outstanding_le4", 32'((rd_next[i] - k[i]) <= 4), 32'd1);
        end
        if (prev_stall[i]) begin
          check("hold_valid", 32'(m_valid[i]), 32'd1);
          check("hold_data", 32'(m_data[i]), 32'(prev_data[i]));
        end
        if (m_valid[i]) begin
          exp_d = base(i) + 16'(k[i]);
          check("pix_in_frame", 32'(k[i] < npix(i)), 32'd1);
          check("pix_data", 32'(m_data[i]), 32'(exp_d));
          check("pix_sof", 32'(sof[i]), 32'(k[i] == 0));
          check("pix_eol", 32'(eol[i]), 32'((k[i] % line_w(i)) == line_w(i) - 1));
          check("pix_eof", 32'(eof[i]), 32'(k[i] == npix(i) - 1));
          if (m_ready[i]) begin
            hs_total[i]++;
            if (eol[i]) n_eol[i]++;
            if (eof[i]) n_eof[i]++;
            k[i]++;
            if (k[i] == npix(i)) exp_done[i] = 1'b1;
          end
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_data[i]  = m_data[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done on instance i; returns cycles waited, flags a timeout.
  task automatic wait_done(input int i, input int bound, input bit rand_ready, output int cyc);
    cyc = 0;
    while (!done[i] && cyc < bound) begin
      if (rand_ready) m_ready[i] = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("done_seen", 32'(done[i]), 32'd1);
  endtask

  initial begin
    int cyc;
    int hs0;
    int eol0;
    int eof0;

    rst = 2'b11; start = 2'b00; m_ready = 2'b00;
    repeat (3) tick();

    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_rd_en", 32'(rd_en[0]), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_valid", 32'(m_valid[0]), 32'd0);
    check("rst_data", 32'(m_data[0]), 32'd0);
    check("rst_markers", 32'({sof[0], eol[0], eof[0]}), 32'd0);
    check("rst_big_valid", 32'(m_valid[1]), 32'd0);
    rst = 2'b00;
    tick();

    fork
      begin : big_frame
        int bcyc;
        m_ready[1] = 1'b1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        bcyc = 0;
        while (!done[1] && bcyc < 150000) begin
          m_ready[1] = ($urandom_range(0, 15) != 0);
          tick();
          bcyc++;
        end
        check("big_done_seen", 32'(done[1]), 32'd1);
        check("big_handshakes", 32'(hs_total[1]), 32'd76800);
        check("big_eol_count", 32'(n_eol[1]), 32'd240);
        check("big_eof_count", 32'(n_eof[1]), 32'd1);
      end

      begin : small_tests
        // Full frame with latency checks.
        m_ready[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("lat_rd_en_t1", 32'(rd_en[0]), 32'd1);
        check("lat_addr_t1", 32'(s_addr), 32'd0);
        check("lat_busy_t1", 32'(busy[0]), 32'd1);
        check("lat_valid_t1", 32'(m_valid[0]), 32'd0);
        tick();
        check("lat_valid_t2", 32'(m_valid[0]), 32'd0);
        tick();
        check("lat_valid_t3", 32'(m_valid[0]), 32'd1);
        check("first_data", 32'(m_data[0]), 32'h0000A000);
        check("first_sof", 32'(sof[0]), 32'd1);
        hs0 = hs_total[0]; eol0 = n_eol[0]; eof0 = n_eof[0];
        wait_done(0, 100, 1'b0, cyc);
        check("done_after_12", 32'(cyc), 32'd12);
        check("busy_low_done", 32'(busy[0]), 32'd0);
        check("frame1_hs", 32'(hs_total[0] - hs0), 32'd12);
        check("frame1_eol", 32'(n_eol[0] - eol0), 32'd3);
        check("frame1_eof", 32'(n_eof[0] - eof0), 32'd1);

        // Start during the done cycle is ignored.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("start_in_done_busy", 32'(busy[0]), 32'd0);
        check("start_in_done_rd", 32'(rd_en[0]), 32'd0);
        repeat (2) tick();

        // Backpressure mid-frame.
        hs0 = hs_total[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        m_ready[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
          tick();
          check("bp_valid", 32'(m_valid[0]), 32'd1);
          if (j >= 4) check("bp_rd_stop", 32'(rd_en[0]), 32'd0);
        end
        m_ready[0] = 1'b1;
        wait_done(0, 100, 1'b0, cyc);
        check("bp_frame_hs", 32'(hs_total[0] - hs0), 32'd12);
        tick();

        // Random ready, two frames.
        for (int f = 0; f < 2; f++) begin
          hs0 = hs_total[0]; eol0 = n_eol[0];
          start[0] = 1'b1;
          tick();
          start[0] = 1'b0;
          wait_done(0, 400, 1'b1, cyc);
          check("rand_frame_hs", 32'(hs_total[0] - hs0), 32'd12);
          check("rand_frame_eol", 32'(n_eol[0] - eol0), 32'd3);
          tick();
        end

        // Second start mid-frame, then reset after handshake 5.
        m_ready[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("restart_busy", 32'(busy[0]), 32'd1);
        cyc = 0;
        while (k[0] < 5 && cyc < 50) begin
          tick();
          cyc++;
        end
        check("reached_hs5", 32'(k[0]), 32'd5);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("mid_rst_valid", 32'(m_valid[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_done", 32'(done[0]), 32'd0);
        for (int j = 0; j < 5; j++) begin
          tick();
          check("post_rst_idle_rd", 32'(rd_en[0]), 32'd0);
          check("post_rst_idle_busy", 32'(busy[0]), 32'd0);
        end
        hs0 = hs_total[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (2) tick();
        check("restart_valid", 32'(m_valid[0]), 32'd1);
        check("restart_data", 32'(m_data[0]), 32'h0000A000);
        check("restart_sof", 32'(sof[0]), 32'd1);
        wait_done(0, 100, 1'b0, cyc);
        check("restart_frame_hs", 32'(hs_total[0] - hs0), 32'd12);
      end
    join

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
